hub75_fbuf_arbiter: RTL and testbench

- Owns the shared single-port framebuffer RAM. Arbitrates it between the fetchshift reader, which needs low latency, and the host pixel writer.
- Manages double buffering. The reader always sees the front bank and the writer always targets the back bank.
- Banks swap only at a frame boundary signalled by the main FSM, so a frame is never displayed torn.
- Sits between the hub75 main FSM / fetchshift block, the host write path and the RAM macro.

---
 rtl/hub75_pkg.sv | 10 +
 rtl/hub75_fbuf_arbiter_if.sv | 23 ++
 rtl/hub75_rdlat_pipe.sv | 20 ++
 rtl/hub75_fbuf_arbiter.sv | 69 ++++++
 tb/tb_hub75_fbuf_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hub75_pkg.sv
// hub75_pkg: shared types, default widths and address helper for the hub75 framebuffer slice.
package hub75_pkg;
    typedef enum logic {ARB, SWAP} arb_state_t;
    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 24;
    // RAM address carries the bank select above the per-bank word address
    function automatic int ram_addr_w(input int addr_w);
        return addr_w + 1;
    endfunction
endpackage

// File: rtl/hub75_fbuf_arbiter_if.sv
// hub75_fbuf_arbiter_if: reader and host-writer request/grant bus into the framebuffer arbiter.
interface hub75_fbuf_arbiter_if import hub75_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;
    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_gnt, rd_data, rd_valid, wr_gnt
    );
    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_gnt, rd_data, rd_valid, wr_gnt
    );
endinterface

// File: rtl/hub75_rdlat_pipe.sv
// hub75_rdlat_pipe: delays read-grant flags by the RAM latency and exposes RAM data when they emerge.
module hub75_rdlat_pipe #(
    parameter int LAT    = 1,
    parameter int DATA_W = 24
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);
    logic [LAT-1:0] sr;
    always_ff @(posedge sys_clk or negedge rst_n)
        if (!rst_n) sr <= '0;
        else sr <= (sr << 1) | LAT'(in_valid);
    // RAM output is already aligned with the delayed flag; mask keeps rd_data quiet otherwise
    assign out_valid = sr[LAT-1];
    assign out_data  = out_valid ? in_data : '0;
endmodule

// File: rtl/hub75_fbuf_arbiter.sv
// hub75_fbuf_arbiter: single-port framebuffer arbiter with read priority, write anti-starvation
// and frame-aligned double-buffer bank swap.
module hub75_fbuf_arbiter import hub75_pkg::*; #(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RAM_LAT    = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic                             sys_clk,
    input  logic                             rst_n,
    hub75_fbuf_arbiter_if.slave              bus,
    input  logic                             swap_req,
    input  logic                             frame_start,
    output logic                             swap_pending,
    output logic                             swap_done,
    output logic                             front_bank,
    output logic                             ram_en,
    output logic                             ram_we,
    output logic [ram_addr_w(ADDR_W)-1:0]    ram_addr,
    output logic [DATA_W-1:0]                ram_wdata,
    input  logic [DATA_W-1:0]                ram_rdata
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    arb_state_t    state, state_nx;
    logic [SW-1:0] starve;
    logic          arb, starved;

    always_ff @(posedge sys_clk or negedge rst_n)
        if (!rst_n) state <= ARB;
        else state <= state_nx;

    always_comb
        state_nx = (state == ARB && frame_start && (swap_pending || swap_req)) ? SWAP : ARB;

    // grants are gated by rst_n so every strobe drops the instant reset asserts
    always_comb begin
        arb         = rst_n && state == ARB;
        starved     = starve == SW'(STARVE_MAX);
        bus.wr_gnt  = arb && bus.wr_req && !swap_pending && (!bus.rd_req || starved);
        bus.rd_gnt  = arb && bus.rd_req && !bus.wr_gnt;
        ram_en      = bus.rd_gnt || bus.wr_gnt;
        ram_we      = bus.wr_gnt;
        ram_addr    = bus.wr_gnt ? {~front_bank, bus.wr_addr} : bus.rd_gnt ? {front_bank, bus.rd_addr} : '0;
        ram_wdata   = bus.wr_gnt ? bus.wr_data : '0;
    end

    always_ff @(posedge sys_clk or negedge rst_n)
        if (!rst_n) begin
            starve       <= '0;
            swap_pending <= 1'b0;
            swap_done    <= 1'b0;
            front_bank   <= 1'b0;
        end else begin
            starve       <= (!bus.wr_req || bus.wr_gnt) ? '0 :
                            (bus.rd_gnt && !swap_pending && !starved) ? starve + 1'b1 : starve;
            swap_pending <= (state == SWAP) ? swap_req : swap_pending || swap_req;
            swap_done    <= state == SWAP;
            front_bank   <= front_bank ^ (state == SWAP);
        end

    hub75_rdlat_pipe #(.LAT(RAM_LAT), .DATA_W(DATA_W)) u_rdlat (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .in_valid  (bus.rd_gnt),
        .in_data   (ram_rdata),
        .out_valid (bus.rd_valid),
        .out_data  (bus.rd_data)
    );
endmodule

// File: tb/tb_hub75_fbuf_arbiter.sv
// tb_hub75_fbuf_arbiter: scoreboard bench driving a RAM_LAT=1 and a RAM_LAT=2 arbiter with shared stimulus.
module tb_hub75_fbuf_arbiter;
    localparam int AW = 11;
    localparam int DW = 24;
    localparam int SM = 8;

    typedef struct {
        logic rg, wg;
        logic [AW:0] a;
        logic [DW-1:0] wd;
        logic fb, sp, sd;
    } cexp_t;
    typedef struct {
        int due;
        logic [DW-1:0] d;
    } rexp_t;

    logic clk = 0;
    logic rst_n = 0;
    logic init = 0;
    logic mon_en = 0;
    logic swap_req = 0, frame_start = 0;
    logic sp0, sd0, fb0, en0, we0, sp1, sd1, fb1, en1, we1;
    logic [AW:0] a0, a1;
    logic [DW-1:0] wd0, wd1, rr0, rr1, s1;
    logic [DW-1:0] mem0 [0:4095];
    logic [DW-1:0] mem1 [0:4095];
    logic [DW-1:0] refmem [0:4095];
    int errors = 0, checks = 0, cyc = 0;
    cexp_t q_cyc[$];
    rexp_t rq0[$], rq1[$];
    cexp_t ce;
    rexp_t r;
    logic m_fb, m_pend, m_swap, m_done;
    int m_starve;

    always #5 clk = ~clk;

    hub75_fbuf_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
    hub75_fbuf_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();

    hub75_fbuf_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(1), .STARVE_MAX(SM)) u0 (
        .sys_clk(clk), .rst_n(rst_n), .bus(b0), .swap_req(swap_req), .frame_start(frame_start),
        .swap_pending(sp0), .swap_done(sd0), .front_bank(fb0), .ram_en(en0), .ram_we(we0),
        .ram_addr(a0), .ram_wdata(wd0), .ram_rdata(rr0));
    hub75_fbuf_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(2), .STARVE_MAX(SM)) u1 (
        .sys_clk(clk), .rst_n(rst_n), .bus(b1), .swap_req(swap_req), .frame_start(frame_start),
        .swap_pending(sp1), .swap_done(sd1), .front_bank(fb1), .ram_en(en1), .ram_we(we1),
        .ram_addr(a1), .ram_wdata(wd1), .ram_rdata(rr1));

    function automatic logic [DW-1:0] seed(input int i);
        return DW'(i * 40503 + 7);
    endfunction

    // behavioural RAMs: one-cycle and two-cycle read latency
    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 4096; i++) begin
                mem0[i] <= seed(i);
                mem1[i] <= seed(i);
            end
        end else begin
            if (en0 && we0) mem0[a0] <= wd0;
            if (en1 && we1) mem1[a1] <= wd1;
        end
        rr0 <= mem0[a0];
        s1  <= mem1[a1];
        rr1 <= s1;
    end

    task automatic cmp(input string n, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", n, k, cyc, act, exp);
        end
    endtask

    task automatic chk_cyc(input int k, input cexp_t e, input logic rg, input logic wg, input logic en,
                           input logic we, input logic [AW:0] a, input logic [DW-1:0] wd,
                           input logic fb, input logic sp, input logic sd);
        cmp("rd_gnt", k, rg, e.rg);
        cmp("wr_gnt", k, wg, e.wg);
        cmp("ram_en", k, en, e.rg | e.wg);
        cmp("ram_we", k, we, e.wg);
        if (e.rg || e.wg) cmp("ram_addr", k, a, e.a);
        if (e.wg) cmp("ram_wdata", k, wd, e.wd);
        cmp("front_bank", k, fb, e.fb);
        cmp("swap_pending", k, sp, e.sp);
        cmp("swap_done", k, sd, e.sd);
    endtask

    task automatic chk_zero(input int k, input logic [3:0] g, input logic [AW:0] a, input logic [DW-1:0] wd,
                            input logic [DW:0] rv, input logic [2:0] s);
        cmp("rst_strobes", k, g, 0);
        cmp("rst_ram_addr", k, a, 0);
        cmp("rst_ram_wdata", k, wd, 0);
        cmp("rst_rd_out", k, rv, 0);
        cmp("rst_swap_bank", k, s, 0);
    endtask

    task automatic model_reset();
        m_fb = 0; m_pend = 0; m_swap = 0; m_done = 0; m_starve = 0;
    endtask

    // one clock of stimulus; the reference model predicts this cycle's outputs then advances
    task automatic step(input logic rd, input logic [AW-1:0] ra, input logic wr, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic sw, input logic fs);
        logic rg, wg, nx_swap;
        logic [AW:0] ea;
        @(posedge clk);
        #1;
        cyc++;
        b0.rd_req = rd; b0.rd_addr = ra; b0.wr_req = wr; b0.wr_addr = wa; b0.wr_data = wd;
        b1.rd_req = rd; b1.rd_addr = ra; b1.wr_req = wr; b1.wr_addr = wa; b1.wr_data = wd;
        swap_req = sw; frame_start = fs;
        wg = !m_swap && wr && !m_pend && (!rd || m_starve == SM);
        rg = !m_swap && rd && !wg;
        ea = wg ? {~m_fb, wa} : {m_fb, ra};
        q_cyc.push_back('{rg, wg, ea, wd, m_fb, m_pend, m_done});
        if (rg) begin
            rq0.push_back('{cyc + 1, refmem[ea]});
            rq1.push_back('{cyc + 2, refmem[ea]});
        end
        if (wg) refmem[ea] = wd;
        if (!wr || wg) m_starve = 0;
        else if (rg && !m_pend && m_starve < SM) m_starve++;
        m_done = m_swap;
        nx_swap = !m_swap && fs && (m_pend || sw);
        if (m_swap) begin
            m_fb = !m_fb;
            m_pend = sw;
        end else m_pend = m_pend || sw;
        m_swap = nx_swap;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk)
        if (mon_en && q_cyc.size() != 0) begin
            ce = q_cyc.pop_front();
            chk_cyc(0, ce, b0.rd_gnt, b0.wr_gnt, en0, we0, a0, wd0, fb0, sp0, sd0);
            chk_cyc(1, ce, b1.rd_gnt, b1.wr_gnt, en1, we1, a1, wd1, fb1, sp1, sd1);
        end

    always @(negedge clk)
        if (mon_en) begin
            if (b0.rd_valid) begin
                if (rq0.size() == 0) cmp("rd_valid_extra", 0, b0.rd_valid, 0);
                else begin
                    r = rq0.pop_front();
                    cmp("rd_latency", 0, cyc, r.due);
                    cmp("rd_data", 0, b0.rd_data, r.d);
                end
            end else if (rq0.size() != 0 && rq0[0].due <= cyc) begin
                r = rq0.pop_front();
                cmp("rd_valid_missing", 0, b0.rd_valid, 1);
            end
            if (b1.rd_valid) begin
                if (rq1.size() == 0) cmp("rd_valid_extra", 1, b1.rd_valid, 0);
                else begin
                    r = rq1.pop_front();
                    cmp("rd_latency", 1, cyc, r.due);
                    cmp("rd_data", 1, b1.rd_data, r.d);
                end
            end else if (rq1.size() != 0 && rq1[0].due <= cyc) begin
                r = rq1.pop_front();
                cmp("rd_valid_missing", 1, b1.rd_valid, 1);
            end
        end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] wa;
        b0.rd_req = 0; b0.rd_addr = 0; b0.wr_req = 0; b0.wr_addr = 0; b0.wr_data = 0;
        b1.rd_req = 0; b1.rd_addr = 0; b1.wr_req = 0; b1.wr_addr = 0; b1.wr_data = 0;
        for (int i = 0; i < 4096; i++) refmem[i] = seed(i);
        model_reset();
        init = 1;
        repeat (3) @(posedge clk);
        init = 0;
        #1;
        chk_zero(0, {b0.rd_gnt, b0.wr_gnt, en0, we0}, a0, wd0, {b0.rd_valid, b0.rd_data}, {sp0, sd0, fb0});
        chk_zero(1, {b1.rd_gnt, b1.wr_gnt, en1, we1}, a1, wd1, {b1.rd_valid, b1.rd_data}, {sp1, sd1, fb1});
        @(negedge clk);
        rst_n = 1;
        mon_en = 1;
        // streaming reads from the front bank
        for (int i = 0; i < 16; i++) step(1, AW'(i), 0, 0, 0, 0, 0);
        // read and write contending: 8 reads then 1 write
        wa = AW'($urandom_range(0, 63));
        for (int i = 0; i < 30; i++) step(1, AW'(i), 1, wa, DW'($urandom), 0, 0);
        idle(2);
        // writes blocked while a swap is pending, then swap on frame_start
        step(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, wa, DW'($urandom), i == 1, 0);
        step(0, 0, 1, wa, DW'($urandom), 0, 1);
        step(1, 3, 1, wa, DW'($urandom), 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, AW'(wa + i), DW'($urandom), 0, 0);
        // swap request and frame start together
        step(0, 0, 0, 0, 0, 1, 1);
        step(1, 4, 0, 0, 0, 0, 0);
        step(1, wa, 0, 0, 0, 0, 0);
        // read in flight across SWAP; a new request during SWAP is latched
        step(0, 0, 1, 5, DW'($urandom), 1, 0);
        step(1, 5, 0, 0, 0, 0, 1);
        step(1, 5, 0, 0, 0, 1, 0);
        step(1, 5, 1, 6, DW'($urandom), 0, 0);
        step(1, 6, 0, 0, 0, 0, 1);
        step(1, 6, 0, 0, 0, 0, 0);
        idle(3);
        // randomized traffic
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, AW'($urandom_range(0, 63)), $urandom_range(0, 2) != 0,
                 AW'($urandom_range(0, 63)), DW'($urandom), $urandom_range(0, 39) == 0,
                 $urandom_range(0, 24) == 0);
        idle(4);
        // asynchronous reset with a read in flight and a swap pending
        step(0, 0, 0, 0, 0, 1, 0);
        step(1, 9, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        mon_en = 0;
        b0.rd_req = 1; b0.wr_req = 1; b1.rd_req = 1; b1.wr_req = 1;
        rst_n = 0;
        #1;
        chk_zero(0, {b0.rd_gnt, b0.wr_gnt, en0, we0}, a0, wd0, {b0.rd_valid, b0.rd_data}, {sp0, sd0, fb0});
        chk_zero(1, {b1.rd_gnt, b1.wr_gnt, en1, we1}, a1, wd1, {b1.rd_valid, b1.rd_data}, {sp1, sd1, fb1});
        q_cyc.delete(); rq0.delete(); rq1.delete();
        model_reset();
        b0.rd_req = 0; b0.wr_req = 0; b1.rd_req = 0; b1.wr_req = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        mon_en = 1;
        idle(5);
        step(1, 9, 0, 0, 0, 0, 0);
        idle(4);
        @(posedge clk);
        #1;
        mon_en = 0;
        cmp("rq_drained", 0, rq0.size(), 0);
        cmp("rq_drained", 1, rq1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
